// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryption, one Feistel round per clock.
// A block is taken on in_valid && in_ready. It runs 16 rounds with the subkeys
// in reverse order (K16 first) and is then held on out_valid until out_ready.
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       cipher_text/cipher_key valid
//   in_ready       engine idle, able to accept
//   cipher_text    64-bit ciphertext, bit 63 = DES bit 1
//   cipher_key     64-bit key including parity bits 56,48,..,0
//   out_valid      plain_text valid
//   out_ready      sink accepts plain_text
//   plain_text     recovered plaintext
//   key_parity_err key of the presented block failed odd parity (CHECK_PARITY=1)
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// ROUND | Feistel rounds, cnt 0..15
// DONE  | result held until out_ready
module des_decrypt_iter #(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_text,
  input  logic [63:0] cipher_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_text,
  output logic        key_parity_err
);

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
    44,49,39,56,34,53, 46,42,50,36,29,32};
  // Row-major: index = {row(b1,b6), col(b2..b5)}.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    x = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
    end
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad = bad | ~(^k[8*b +: 8]);
    return bad;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        in_ready_nxt, out_valid_nxt;
  logic [31:0] l_q, r_q, r_new;
  logic [27:0] c_q, d_q, c_rot, d_rot;
  logic [3:0]  cnt_q;
  logic        perr_q;
  logic        accept;
  logic [47:0] subkey;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Decryption walks the key schedule backwards: right rotations, none for K16.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (cnt_q == 4'd1 || cnt_q == 4'd8 || cnt_q == 4'd15) begin
      c_rot = {c_q[0], c_q[27:1]};
      d_rot = {d_q[0], d_q[27:1]};
    end else if (cnt_q != 4'd0) begin
      c_rot = {c_q[1:0], c_q[27:2]};
      d_rot = {d_q[1:0], d_q[27:2]};
    end
  end

  assign subkey = perm_pc2({c_rot, d_rot});
  assign r_new  = l_q ^ feistel(r_q, subkey);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (cnt_q == 4'd15) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q            <= '0;
      r_q            <= '0;
      c_q            <= '0;
      d_q            <= '0;
      cnt_q          <= '0;
      perr_q         <= 1'b0;
      plain_text     <= '0;
      key_parity_err <= 1'b0;
    end else if (accept) begin
      {l_q, r_q} <= perm_ip(cipher_text);
      {c_q, d_q} <= perm_pc1(cipher_key);
      perr_q     <= parity_bad(cipher_key);
      cnt_q      <= '0;
    end else if (state == ROUND) begin
      l_q   <= r_q;
      r_q   <= r_new;
      c_q   <= c_rot;
      d_q   <= d_rot;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        plain_text     <= perm_fp({r_new, r_q});
        key_parity_err <= perr_q & CHECK_PARITY;
      end
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
`timescale 1ns/1ps
module tb_des_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] cipher_text = '0;
  logic [63:0] cipher_key = '0;
  logic        in_ready, out_valid, key_parity_err;
  logic [63:0] plain_text;
  logic        np_in_ready, np_out_valid, np_key_parity_err;
  logic [63:0] np_plain_text;

  always #5 clk = ~clk;

  des_decrypt_iter #(.CHECK_PARITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_text(cipher_text), .cipher_key(cipher_key), .out_valid(out_valid),
    .out_ready(out_ready), .plain_text(plain_text), .key_parity_err(key_parity_err));

  des_decrypt_iter #(.CHECK_PARITY(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(np_in_ready),
    .cipher_text(cipher_text), .cipher_key(cipher_key), .out_valid(np_out_valid),
    .out_ready(out_ready), .plain_text(np_plain_text), .key_parity_err(np_key_parity_err));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference DES (software form) ----------------
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
    44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    int row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      row = 2 * int'(x[47-6*b]) + int'(x[42-6*b]);
      col = int'(x[46-6*b -: 4]);
      s[31-4*b -: 4] = 4'(SB[b][row][col]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  // Forward key schedule (left shifts), decryption just reads it backwards.
  function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk,
                                          input bit decrypt);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] lr, pre, res;
    logic [31:0] l, r, t;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      repeat ((i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-PC2_T[j]];
    end
    for (int i = 0; i < 64; i++) lr[63-i] = blk[64-IP_T[i]];
    l = lr[63:32];
    r = lr[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ ref_f(r, decrypt ? ks[15-i] : ks[i]);
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  function automatic bit ref_parity_bad(input logic [63:0] key);
    bit bad = 1'b0;
    for (int b = 0; b < 8; b++)
      if ($countones(key[8*b +: 8]) % 2 == 0) bad = 1'b1;
    return bad;
  endfunction

  // ---------------- transaction/timing model ----------------
  // phase 0: idle, 1: computing (rounds_left edges to go), 2: holding result
  int          m_phase = 0;
  int          m_rounds_left = 0;
  bit          m_in_ready = 1'b0;
  bit          m_out_valid = 1'b0;
  bit          m_perr = 1'b0, m_next_perr = 1'b0;
  logic [63:0] m_pt = '0, m_next_pt = '0;
  int          cyc = 0;
  int          acc_count = 0;
  int          last_acc_cyc = 0;
  int          hs_count = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_in_ready = 1'b0; m_out_valid = 1'b0;
      m_perr = 1'b0; m_pt = '0;
    end else begin
      cyc++;
      if (m_phase == 0) begin
        if (m_in_ready && in_valid) begin
          m_next_pt     = ref_des(cipher_key, cipher_text, 1'b1);
          m_next_perr   = ref_parity_bad(cipher_key);
          m_rounds_left = 16;
          m_in_ready    = 1'b0;
          m_phase       = 1;
          acc_count++;
          last_acc_cyc  = cyc;
        end else begin
          m_in_ready = 1'b1;
        end
      end else if (m_phase == 1) begin
        m_rounds_left--;
        if (m_rounds_left == 0) begin
          m_out_valid = 1'b1;
          m_pt        = m_next_pt;
          m_perr      = m_next_perr;
          m_phase     = 2;
        end
      end else if (out_ready) begin
        m_out_valid = 1'b0;
        m_in_ready  = 1'b1;
        m_phase     = 0;
        hs_count++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          lb_active = 1'b0;
  logic [63:0] lb_q [$];

  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(m_in_ready));
      chk("out_valid", 64'(out_valid), 64'(m_out_valid));
      chk("np_in_ready", 64'(np_in_ready), 64'(m_in_ready));
      chk("np_out_valid", 64'(np_out_valid), 64'(m_out_valid));
      if (m_out_valid || !rst_n) begin
        chk("plain_text", plain_text, m_pt);
        chk("key_parity_err", 64'(key_parity_err), 64'(m_perr));
        chk("np_plain_text", np_plain_text, m_pt);
        chk("np_key_parity_err", 64'(np_key_parity_err), 64'd0);
      end
      if (lb_active && m_out_valid && out_ready) begin
        if (lb_q.size() == 0) chk("loopback_queue_empty", 64'd1, 64'd0);
        else chk("loopback_pt", plain_text, lb_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_block(input logic [63:0] key, input logic [63:0] ct);
    int start, n;
    start = acc_count;
    n = 0;
    cipher_key = key;
    cipher_text = ct;
    in_valid = 1'b1;
    while (acc_count == start && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    cipher_key = {$urandom, $urandom};
    cipher_text = {$urandom, $urandom};
    if (acc_count == start) chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_out(output int latency);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) chk("out_valid_timeout", 64'd1, 64'd0);
    latency = cyc - last_acc_cyc;
  endtask

  task automatic take_out();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] C1 = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K2 = 64'h0E32_9232_EA6D_0D73;
  localparam logic [63:0] P2 = 64'h8787_8787_8787_8787;
  localparam logic [63:0] C4 = 64'h8CA6_4DE9_C1B1_23A7;

  initial begin
    int lat, base, n;
    logic [63:0] k, p, held;

    chk("model_kat1_dec", ref_des(K1, C1, 1'b1), P1);
    chk("model_kat1_enc", ref_des(K1, P1, 1'b0), C1);
    chk("model_kat2_dec", ref_des(K2, 64'd0, 1'b1), P2);
    chk("model_kat4_dec", ref_des(64'd0, C4, 1'b1), 64'd0);
    chk("model_parity_k0", 64'(ref_parity_bad(64'd0)), 64'd1);
    chk("model_parity_k1", 64'(ref_parity_bad(K1)), 64'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_plain_text", plain_text, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);

    // case 1 + backpressure
    send_block(K1, C1);
    wait_out(lat);
    chk("kat1_latency", 64'(lat), 64'd16);
    chk("kat1_pt", plain_text, P1);
    chk("kat1_perr", 64'(key_parity_err), 64'd0);
    held = plain_text;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      cipher_text = {$urandom, $urandom};
      cipher_key = {$urandom, $urandom};
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pt_held", plain_text, held);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("out_valid_after_hs", 64'(out_valid), 64'd0);

    // case 2
    send_block(K2, 64'd0);
    wait_out(lat);
    chk("kat2_pt", plain_text, P2);
    take_out();

    // case 4: parity
    send_block(64'd0, C4);
    wait_out(lat);
    chk("kat4_pt", plain_text, 64'd0);
    chk("kat4_perr", 64'(key_parity_err), 64'd1);
    chk("kat4_np_perr", 64'(np_key_parity_err), 64'd0);
    chk("kat4_np_pt", np_plain_text, 64'd0);
    take_out();

    // case 5: reset at round 8 of case 1, then case 2
    send_block(K1, C1);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_plain_text", plain_text, 64'd0);
    chk("midrst_perr", 64'(key_parity_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_block(K2, 64'd0);
    wait_out(lat);
    chk("post_rst_latency", 64'(lat), 64'd16);
    chk("post_rst_kat2_pt", plain_text, P2);
    take_out();

    // case 6: randomized loopback
    lb_active = 1'b1;
    base = hs_count;
    fork
      begin
        for (int b = 0; b < 200; b++) begin
          k = {$urandom, $urandom};
          p = {$urandom, $urandom};
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          lb_q.push_back(p);
          send_block(k, ref_des(k, p, 1'b0));
        end
      end
      begin
        n = 0;
        while (hs_count < base + 200 && n < 20000) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
          n++;
        end
        out_ready = 1'b0;
      end
    join
    chk("loopback_count", 64'(hs_count - base), 64'd200);
    chk("loopback_leftover", 64'(lb_q.size()), 64'd0);
    lb_active = 1'b0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
